// File: rtl/i2c_slave_regmap_if.sv
// Byte-level link between the I2C slave bit engine (master side) and the
// register-file back end (slave side).
interface i2c_slave_regmap_if;
  logic       frame_start;
  logic       frame_rw;
  logic       frame_stop;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_req;
  logic [7:0] tx_data;

  modport master (
    output frame_start, frame_rw, frame_stop, rx_valid, rx_data, tx_req,
    input  tx_data
  );

  modport slave (
    input  frame_start, frame_rw, frame_stop, rx_valid, rx_data, tx_req,
    output tx_data
  );
endinterface

// File: rtl/i2c_slave_regmap.sv
// Pointer-based I2C register file: first written byte sets the pointer, further
// writes and all reads auto-increment it. Runs on the bus clock.
module i2c_slave_regmap #(
  parameter int                   G_NB_REGS   = 16,
  parameter int                   G_PTR_W     = 4,
  parameter logic [7:0]           G_RESET_VAL = 8'h00,
  parameter logic [G_NB_REGS-1:0] G_RO_MASK   = '0
) (
  input  logic               sclk_in,
  input  logic               rst_n,
  i2c_slave_regmap_if.slave  bus,
  output logic               wr_pulse,
  output logic [G_PTR_W-1:0] wr_addr,
  output logic [7:0]         wr_data,
  output logic [G_PTR_W-1:0] ptr_o,
  output logic               ptr_err,
  output logic [7:0]         ro_err_cnt,
  input  logic [G_PTR_W-1:0] dbg_addr,
  output logic [7:0]         dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_WRITE, S_READ} state_e;

  state_e             state_q, state_d;
  logic [7:0]         regs_q [G_NB_REGS];
  logic [7:0]         regs_d [G_NB_REGS];
  logic [G_PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               wr_pulse_q, wr_pulse_d;
  logic [G_PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               ptr_err_q, ptr_err_d;
  logic [7:0]         ro_err_cnt_q, ro_err_cnt_d;

  logic [G_PTR_W-1:0] ptr_inc;
  logic               ptr_oob;

  assign ptr_inc = ptr_q + G_PTR_W'(1);
  // Widened compare so that a 256-entry map never flags an out-of-range pointer.
  assign ptr_oob = ({1'b0, bus.rx_data} >= 9'(G_NB_REGS));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    regs_d       = regs_q;
    ptr_d        = ptr_q;
    tx_data_d    = tx_data_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    ptr_err_d    = ptr_err_q;
    ro_err_cnt_d = ro_err_cnt_q;

    if (bus.frame_stop) begin
      state_d = S_IDLE;
    end else if (bus.frame_start) begin
      if (bus.frame_rw) begin
        state_d   = S_READ;
        tx_data_d = regs_q[ptr_q];
        ptr_d     = ptr_inc;
      end else begin
        state_d = S_PTR;
      end
    end else begin
      unique case (state_q)
        S_PTR: if (bus.rx_valid) begin
          ptr_d   = bus.rx_data[G_PTR_W-1:0];
          state_d = S_WRITE;
          if (ptr_oob) ptr_err_d = 1'b1;
        end
        S_WRITE: if (bus.rx_valid) begin
          if (!G_RO_MASK[ptr_q]) begin
            regs_d[ptr_q] = bus.rx_data;
            wr_pulse_d    = 1'b1;
            wr_addr_d     = ptr_q;
            wr_data_d     = bus.rx_data;
          end else if (ro_err_cnt_q != 8'hFF) begin
            ro_err_cnt_d = ro_err_cnt_q + 8'd1;
          end
          ptr_d = ptr_inc;
        end
        S_READ: if (bus.tx_req) begin
          tx_data_d = regs_q[ptr_q];
          ptr_d     = ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the register
  // file is reset too, since every register must read G_RESET_VAL after reset.
  always_ff @(posedge sclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < G_NB_REGS; i++) regs_q[i] <= G_RESET_VAL;
      ptr_q        <= '0;
      tx_data_q    <= 8'h00;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      ptr_err_q    <= 1'b0;
      ro_err_cnt_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      ptr_q        <= ptr_d;
      tx_data_q    <= tx_data_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      ptr_err_q    <= ptr_err_d;
      ro_err_cnt_q <= ro_err_cnt_d;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign ptr_o       = ptr_q;
  assign ptr_err     = ptr_err_q;
  assign ro_err_cnt  = ro_err_cnt_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Scoreboard bench for i2c_slave_regmap: directed test-plan sequences followed by
// random byte traffic, all checked against a frame-level reference model.
module tb_i2c_slave_regmap;

  localparam int             NREGS = 16;
  localparam int             PW    = 4;
  localparam logic [15:0]    RO    = 16'h0004;

  logic          sclk_in = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_pulse;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [PW-1:0] ptr_o;
  logic          ptr_err;
  logic [7:0]    ro_err_cnt;
  logic [PW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_data;

  i2c_slave_regmap_if bus ();

  i2c_slave_regmap #(
    .G_NB_REGS(NREGS), .G_PTR_W(PW), .G_RESET_VAL(8'h00), .G_RO_MASK(RO)
  ) dut (
    .sclk_in(sclk_in), .rst_n(rst_n), .bus(bus),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
    .ptr_o(ptr_o), .ptr_err(ptr_err), .ro_err_cnt(ro_err_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 sclk_in = ~sclk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame mode, pointer, register contents, error counters.
  typedef struct { int addr; int data; } wr_t;
  wr_t wr_q[$];
  int  tx_q[$];
  int  m_regs[NREGS];
  int  m_ptr, m_mode, m_tx, m_ro;  // m_mode: 0 idle, 1 expect pointer, 2 writing, 3 reading
  bit  m_err;

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_ptr = 0; m_mode = 0; m_tx = 0; m_ro = 0; m_err = 0;
    wr_q.delete();
    tx_q.delete();
  endtask

  task automatic model_edge(input bit fs, rw, stop, rv, input int rd, input bit treq);
    if (stop) m_mode = 0;
    else if (fs && rw) begin
      m_mode = 3; m_tx = m_regs[m_ptr]; m_ptr = (m_ptr + 1) % NREGS;
    end else if (fs) m_mode = 1;
    else if (m_mode == 1 && rv) begin
      m_ptr = rd % NREGS; if (rd >= NREGS) m_err = 1; m_mode = 2;
    end else if (m_mode == 2 && rv) begin
      if (RO[m_ptr]) begin
        if (m_ro < 255) m_ro++;
      end else begin
        m_regs[m_ptr] = rd;
        wr_q.push_back('{addr: m_ptr, data: rd});
      end
      m_ptr = (m_ptr + 1) % NREGS;
    end else if (m_mode == 3 && treq) begin
      m_tx = m_regs[m_ptr]; m_ptr = (m_ptr + 1) % NREGS;
    end
    if (treq || (fs && rw)) tx_q.push_back(m_tx);
  endtask

  task automatic clear_inputs();
    bus.frame_start = 0; bus.frame_rw = 0; bus.frame_stop = 0;
    bus.rx_valid = 0; bus.rx_data = 8'h00; bus.tx_req = 0;
  endtask

  // One bus edge: drive at negedge, predict, release inputs after the edge.
  task automatic cycle(input bit fs, rw, stop, rv, input logic [7:0] rd, input bit treq);
    @(negedge sclk_in);
    bus.frame_start = fs; bus.frame_rw = rw; bus.frame_stop = stop;
    bus.rx_valid = rv; bus.rx_data = rd; bus.tx_req = treq;
    model_edge(fs, rw, stop, rv, int'(rd), treq);
    @(posedge sclk_in);
    #1 clear_inputs();
  endtask

  task automatic wbyte(input logic [7:0] d); cycle(0, 0, 0, 1, d, 0); endtask
  task automatic start_w();  cycle(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic start_r();  cycle(1, 1, 0, 0, 8'h00, 0); endtask
  task automatic stop();     cycle(0, 0, 1, 0, 8'h00, 0); endtask
  task automatic treq();     cycle(0, 0, 0, 0, 8'h00, 1); endtask

  task automatic peek(input int a, output logic [7:0] d);
    dbg_addr = PW'(a);
    #1 d = dbg_data;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] d;
    @(negedge sclk_in);
    #1;
    check({tag, "_ptr"}, 32'(ptr_o), 32'(m_ptr));
    check({tag, "_ptr_err"}, 32'(ptr_err), 32'(m_err));
    check({tag, "_ro_cnt"}, 32'(ro_err_cnt), 32'(m_ro));
    check({tag, "_tx"}, 32'(bus.tx_data), 32'(m_tx));
    for (int i = 0; i < NREGS; i++) begin
      peek(i, d);
      check($sformatf("%s_reg%0d", tag, i), 32'(d), 32'(m_regs[i]));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write strobe or a tx load.
  bit  load_seen = 0;
  wr_t mon_e;
  always @(posedge sclk_in)
    load_seen <= rst_n && (bus.tx_req || (bus.frame_start && bus.frame_rw));

  always @(negedge sclk_in) begin
    if (rst_n) begin
      if (wr_pulse) begin
        if (wr_q.size() == 0) check("wr_pulse_unexpected", 32'(wr_pulse), 32'd0);
        else begin
          mon_e = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
        end
      end
      if (load_seen) begin
        if (tx_q.size() == 0) check("tx_unexpected", 32'(load_seen), 32'd0);
        else check("tx_data", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge sclk_in);
    #1 rst_n = 1;
    check_state("reset");
    check("reset_ptr_zero", 32'(ptr_o), 32'd0);

    // Write burst
    start_w(); wbyte(8'h03); wbyte(8'hA1); wbyte(8'hB2); stop();
    check_state("burst");
    peek(3, d); check("burst_reg3", 32'(d), 32'hA1);
    peek(4, d); check("burst_reg4", 32'(d), 32'hB2);
    check("burst_ptr", 32'(ptr_o), 32'd5);

    // Repeated-start read
    start_w(); wbyte(8'h04); start_r(); treq(); treq(); stop();
    check_state("rdrep");
    check("rdrep_ptr", 32'(ptr_o), 32'd7);

    // Pointer wrap
    start_w(); wbyte(8'h0F); wbyte(8'h11); wbyte(8'h22); stop();
    check_state("wrap");
    check("wrap_ptr", 32'(ptr_o), 32'd1);

    // Read-only register and out-of-range pointer
    start_w(); wbyte(8'h12);
    check_state("ptrerr");
    check("ptrerr_flag", 32'(ptr_err), 32'd1);
    wbyte(8'h55); stop();
    check_state("ro");
    check("ro_cnt", 32'(ro_err_cnt), 32'd1);
    peek(2, d); check("ro_reg2", 32'(d), 32'h00);

    // Stop wins over rx_valid on the same edge; stray tx_req outside READ is ignored
    start_w(); wbyte(8'h07); cycle(0, 0, 1, 1, 8'h99, 0);
    treq();
    check_state("prio");

    // Reset mid-burst: pending byte must never land
    start_w(); wbyte(8'h08); wbyte(8'h33);
    @(negedge sclk_in);
    bus.rx_valid = 1; bus.rx_data = 8'h44;
    #2 rst_n = 0;
    #1;
    check("rst_tx", 32'(bus.tx_data), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ptr", 32'(ptr_o), 32'd0);
    check("rst_ptr_err", 32'(ptr_err), 32'd0);
    check("rst_ro_cnt", 32'(ro_err_cnt), 32'd0);
    peek(8, d); check("rst_reg8", 32'(d), 32'd0);
    clear_inputs();
    model_reset();
    repeat (2) @(negedge sclk_in);
    #1 rst_n = 1;
    check_state("postrst");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      automatic bit         r_stop = ($urandom_range(0, 19) == 0);
      automatic bit         r_fs   = ($urandom_range(0, 9) == 0);
      automatic bit         r_rw   = $urandom_range(0, 1) == 1;
      automatic bit         r_rv   = ($urandom_range(0, 9) < 4);
      automatic bit         r_tq   = ($urandom_range(0, 9) < 3);
      automatic logic [7:0] r_d    = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                                 : 8'($urandom_range(0, 15));
      cycle(r_fs, r_rw, r_stop, r_rv, r_d, r_tq);
      if (n % 100 == 99) check_state("rand");
    end
    stop();
    check_state("final");
    repeat (3) @(negedge sclk_in);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
